// File: rtl/ifu_prefetch_pkg.sv
// Shared constants, redirect encoding and sizing helpers for the prefetching
// instruction-fetch unit.
package ifu_prefetch_pkg;

    // Default first fetch address after reset.
    localparam logic [31:0] REBOOT_A = 32'h0000_0000;

    // Source of a fetch redirect in the current cycle, highest priority last.
    typedef enum logic [1:0] {
        REDIR_NONE   = 2'd0,
        REDIR_BRANCH = 2'd1,
        REDIR_FLUSH  = 2'd2
    } redir_e;

    // Bits needed to hold a count in the range 0..n.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n < 32'd1) ? 32'd1 : $clog2(n + 32'd1);
    endfunction

    // Bits needed to index n storage slots (at least one bit).
    function automatic int unsigned ptr_bits(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with synchronous clear. Push while full is accepted only
// when a pop happens in the same cycle. Clear wins over push and pop.
module ifu_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic [cnt_bits(DEPTH)-1:0]  count,
    output logic                        full,
    output logic                        empty
);

    localparam int unsigned PW = ptr_bits(DEPTH);
    localparam int unsigned CW = cnt_bits(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 32'd1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? {PW{1'b0}} : (p + {{(PW-1){1'b0}}, 1'b1});
    endfunction

    // Qualify push/pop against the current fill level.
    always_comb begin
        do_pop_s  = pop && (count_r != {CW{1'b0}});
        do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
    end

    // Pointer and fill-level bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clr) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage; cleared on reset so the read port shows zero until written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s && !clr) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: generates fetch addresses from the branch
// predictor, keeps a bounded number of memory requests in flight, buffers
// returned instructions for decode and discards responses made stale by a
// flush or branch redirect.
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH       = 4,
    parameter int unsigned     MAX_OUT     = 2,
    parameter logic [XLEN-1:0] REBOOT_ADDR = XLEN'(REBOOT_A)
) (
    input  logic            ck_i,
    input  logic            rs_n_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] new_pc_i,
    input  logic            branch_redirect_i,
    input  logic [XLEN-1:0] branch_redirect_pc_i,
    input  logic [XLEN-1:0] next_pc_i,
    input  logic            next_taken_i,
    output logic            req_valid_o,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            req_ready_i,
    input  logic            rsp_valid_i,
    input  logic [XLEN-1:0] rsp_data_i,
    output logic            ins_valid_o,
    input  logic            ins_ready_i,
    output logic [XLEN-1:0] ins_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] next_pc_o,
    output logic            next_taken_o,
    output logic            branch_slot_end_o,
    output logic            stall_req_o
);

    // Record = {pc, predicted next pc, predicted taken, slot flag}.
    localparam int unsigned REC_W = 2 * XLEN + 2;
    localparam int unsigned INS_W = XLEN + REC_W;
    localparam int unsigned RC_W  = cnt_bits(MAX_OUT);
    localparam int unsigned QC_W  = cnt_bits(DEPTH);
    localparam int unsigned SUM_W = cnt_bits(DEPTH + 2 * MAX_OUT);
    localparam logic [SUM_W-1:0] MAX_OUT_C = SUM_W'(MAX_OUT);
    localparam logic [SUM_W-1:0] DEPTH_C   = SUM_W'(DEPTH);

    logic [XLEN-1:0]  fetch_pc_r;
    logic [RC_W-1:0]  drop_cnt_r;
    logic             slot_r;
    logic             run_r;

    redir_e           redir_s;
    logic             redirect_s;
    logic [XLEN-1:0]  redir_pc_s;
    logic [XLEN-1:0]  seq_pc_s;

    logic [RC_W-1:0]  rec_count_s;
    logic             rec_full_s;
    logic             rec_empty_s;
    logic [REC_W-1:0] rec_wdata_s;
    logic [REC_W-1:0] rec_rdata_s;
    logic             rec_pop_s;

    logic [QC_W-1:0]  q_count_s;
    logic             q_full_s;
    logic             q_empty_s;
    logic [INS_W-1:0] q_wdata_s;
    logic [INS_W-1:0] q_rdata_s;
    logic             q_push_s;
    logic             q_pop_s;

    logic [SUM_W-1:0] outstanding_s;
    logic [SUM_W-1:0] credit_sum_s;
    logic             req_valid_s;
    logic             req_fire_s;
    logic             drop_rsp_s;

    // Redirect source selection; flush outranks a branch correction.
    always_comb begin
        redir_s    = REDIR_NONE;
        redir_pc_s = fetch_pc_r;
        if (flush_i) begin
            redir_s    = REDIR_FLUSH;
            redir_pc_s = {new_pc_i[XLEN-1:2], 2'b00};
        end else if (branch_redirect_i) begin
            redir_s    = REDIR_BRANCH;
            redir_pc_s = {branch_redirect_pc_i[XLEN-1:2], 2'b00};
        end else begin
            redir_s    = REDIR_NONE;
            redir_pc_s = fetch_pc_r;
        end
        redirect_s = (redir_s != REDIR_NONE);
    end

    // Credit check: in-flight requests plus buffered instructions never
    // exceed the queue, so every response has a guaranteed slot.
    always_comb begin
        outstanding_s = SUM_W'(rec_count_s) + SUM_W'(drop_cnt_r);
        credit_sum_s  = outstanding_s + SUM_W'(q_count_s);
        req_valid_s   = run_r && !redirect_s && !rec_full_s &&
                        (outstanding_s < MAX_OUT_C) && (credit_sum_s < DEPTH_C);
        req_fire_s    = req_valid_s && req_ready_i;
        if (next_taken_i) begin
            seq_pc_s = {next_pc_i[XLEN-1:2], 2'b00};
        end else begin
            seq_pc_s = fetch_pc_r + XLEN'(32'd4);
        end
    end

    // Response routing: stale responses are absorbed by drop_cnt, live ones
    // pair with their record and enter the queue unless a redirect hits.
    always_comb begin
        drop_rsp_s  = rsp_valid_i && (drop_cnt_r != {RC_W{1'b0}});
        rec_pop_s   = rsp_valid_i && (drop_cnt_r == {RC_W{1'b0}}) && !rec_empty_s;
        q_push_s    = rec_pop_s && !redirect_s;
        q_pop_s     = !q_empty_s && ins_ready_i;
        rec_wdata_s = {fetch_pc_r, next_pc_i, next_taken_i, slot_r};
        q_wdata_s   = {rsp_data_i, rec_rdata_s};
    end

    // Fetch address and branch-slot marker.
    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (!rs_n_i) begin
            fetch_pc_r <= REBOOT_ADDR;
            slot_r     <= 1'b0;
        end else if (redirect_s) begin
            fetch_pc_r <= redir_pc_s;
            slot_r     <= (redir_s == REDIR_BRANCH);
        end else if (req_fire_s) begin
            fetch_pc_r <= seq_pc_s;
            slot_r     <= 1'b0;
        end
    end

    // Count of responses still owed for requests made before a redirect.
    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (!rs_n_i) begin
            drop_cnt_r <= {RC_W{1'b0}};
        end else if (redirect_s) begin
            drop_cnt_r <= RC_W'(outstanding_s - SUM_W'(rsp_valid_i));
        end else if (drop_rsp_s) begin
            drop_cnt_r <= drop_cnt_r - {{(RC_W-1){1'b0}}, 1'b1};
        end
    end

    // Holds off requests during the reset cycle so req_valid_o reads 0.
    always_ff @(posedge ck_i or negedge rs_n_i) begin
        if (!rs_n_i) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    ifu_fifo #(
        .WIDTH (REC_W),
        .DEPTH (MAX_OUT)
    ) u_rec_fifo (
        .clk   (ck_i),
        .rst_n (rs_n_i),
        .clr   (redirect_s),
        .push  (req_fire_s),
        .wdata (rec_wdata_s),
        .pop   (rec_pop_s),
        .rdata (rec_rdata_s),
        .count (rec_count_s),
        .full  (rec_full_s),
        .empty (rec_empty_s)
    );

    ifu_fifo #(
        .WIDTH (INS_W),
        .DEPTH (DEPTH)
    ) u_ins_queue (
        .clk   (ck_i),
        .rst_n (rs_n_i),
        .clr   (redirect_s),
        .push  (q_push_s && (!q_full_s || q_pop_s)),
        .wdata (q_wdata_s),
        .pop   (q_pop_s),
        .rdata (q_rdata_s),
        .count (q_count_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    assign req_valid_o = req_valid_s;
    assign req_addr_o  = fetch_pc_r;
    assign ins_valid_o = !q_empty_s;
    assign stall_req_o = q_empty_s;
    assign {ins_o, pc_o, next_pc_o, next_taken_o, branch_slot_end_o} = q_rdata_s;

endmodule

// File: doc/ifu_prefetch.md
# ifu_prefetch

Parametrised instruction-fetch unit with a decoupled memory request/response interface, a bounded number of in-flight requests, and an instruction queue of configurable depth between fetch and decode. It generates fetch addresses from the branch predictor's next-PC/taken prediction and redirects on flush (exception entry/return) or branch misprediction. Stale responses are discarded after a redirect. It replaces the single-cycle PC register in the core front end and sits between the CTL/BP/EX units, the instruction memory and decode.

## Interface
- XLEN, 32: address and instruction width.
- DEPTH, 4: instruction queue entries; power of two, at least 2.
- MAX_OUT, 2: maximum outstanding memory requests; at least 1 and at most DEPTH.
- REBOOT_ADDR, `REBOOT_A: first fetch address after reset.

- ck_i  in  1  clock.
- rs_n_i  in  1  reset; asynchronous, active-low.
- flush_i  in  1  CTL redirect; highest priority.
- new_pc_i  in  XLEN  flush target.
- branch_redirect_i  in  1  EX misprediction redirect.
- branch_redirect_pc_i  in  XLEN  corrected target.
- next_pc_i  in  XLEN  BP predicted next PC for req_addr_o; combinational lookup.
- next_taken_i  in  1  BP predicts taken.
- req_valid_o  out  1  memory request valid.
- req_addr_o  out  XLEN  request address; word aligned.
- req_ready_i  in  1  memory accepts request.
- rsp_valid_i  in  1  response valid; strictly in request order, no backpressure.
- rsp_data_i  in  XLEN  instruction word.
- ins_valid_o  out  1  queue head valid.
- ins_ready_i  in  1  decode consumes head.
- ins_o  out  XLEN  instruction.
- pc_o  out  XLEN  PC of ins_o.
- next_pc_o  out  XLEN  predicted next PC stored with ins_o, for EX checking.
- next_taken_o  out  1  prediction stored with ins_o.
- branch_slot_end_o  out  1  ins_o is the first instruction after a branch redirect.
- stall_req_o  out  1  equals !ins_valid_o; the front end has nothing to deliver.

## Operation
- fetch_pc register:
  - Request issue: req_valid_o = !redirect && (outstanding < MAX_OUT) && (outstanding + occupancy < DEPTH), where redirect = flush_i | branch_redirect_i.
  - On handshake (req_valid_o & req_ready_i):
    - Push {fetch_pc, next_pc_i, next_taken_i, slot_flag} into the in-flight record FIFO.
    - fetch_pc <= next_taken_i ? next_pc_i : fetch_pc + 4, with modulo 2^XLEN wrap.
    - Clear slot_flag.
- Response (rsp_valid_i): pop the oldest record.
  - If drop_cnt > 0: decrement drop_cnt and discard the data.
  - Otherwise push {rsp_data_i, record} into the instruction queue.
  - Because of the credit rule, the queue can never overflow.
- Redirect priority: flush_i over branch_redirect_i over normal fetch.
  - fetch_pc <= new_pc_i or branch_redirect_pc_i.
  - Instruction queue cleared, including any same-cycle push.
  - Record FIFO cleared.
  - drop_cnt <= outstanding − rsp_valid_i; the current response is dropped.
  - slot_flag <= 1 on a branch redirect, 0 on a flush.
- Until the response at slot_flag's address arrives, slot_flag stays with the record, so branch_slot_end_o marks exactly one instruction.
- outstanding = record count + drop_cnt; it never exceeds MAX_OUT.
- Pop happens when ins_valid_o & ins_ready_i. Pop and push in the same cycle are legal at any occupancy, including full.
- Unaligned redirect targets: bits [1:0] forced to 0.

## Timing
- Reset (asynchronous) values:
  - fetch_pc = REBOOT_ADDR; queue and records empty; drop_cnt = 0; slot_flag = 0.
  - req_valid_o = 0, ins_valid_o = 0, branch_slot_end_o = 0, stall_req_o = 1.
  - Remaining data outputs are 0.
- Mid-operation reset discards everything. The memory shares rs_n_i and returns no pre-reset responses.
- First cycle after reset release: req_valid_o = 1, req_addr_o = REBOOT_ADDR.
- Latency: a response in cycle t appears on ins_o in cycle t+1. With zero-wait memory (response one cycle after acceptance), request to ins_valid_o takes 2 cycles.
- Redirect asserted in cycle t: req_valid_o = 0 in t; first request to the target in t+1; ins_valid_o = 0 in t+1.
- Request handshake: req_addr_o is stable while req_valid_o & !req_ready_i, except when a redirect withdraws the request.

## Structure
- Shared defines stay in defines.v: `INS_BUS_A, `REBOOT_A, `Branch, `RST_EN.
- One sub-module, ifu_fifo: synchronous FIFO with parameters WIDTH and DEPTH, a synchronous clear, and count/full/empty outputs.
  - Instance 1: record FIFO, MAX_OUT entries.
  - Instance 2: instruction queue, DEPTH entries.
- The top level holds fetch_pc, drop_cnt, slot_flag and the credit logic.

## Test plan
- Reset release, memory always ready with 1-cycle response, decode always ready, no prediction:
  - Requests issue to 0x0, 0x4, 0x8, and so on.
  - ins_valid_o rises in cycle 2 with pc_o = 0x0.
  - One instruction per cycle thereafter.
- ins_ready_i = 0, DEPTH = 4, MAX_OUT = 2: exactly 4 instructions are queued and req_valid_o drops. Raising ins_ready_i resumes in-order delivery with no loss or duplication.
- BP predicts taken at 0x8 to 0x100: next request address is 0x100. The 0x8 entry shows next_pc_o = 0x100, next_taken_o = 1.
- Two requests outstanding, then branch_redirect_i to 0x200 in the same cycle as a response:
  - Both old responses are discarded.
  - The first delivered instruction has pc_o = 0x200 and branch_slot_end_o = 1; the next has branch_slot_end_o = 0.
- flush_i and branch_redirect_i in the same cycle (new_pc_i = 0x80, branch target 0x200):
  - Fetch resumes at 0x80.
  - branch_slot_end_o stays 0.
- rs_n_i pulsed low mid-stream with a full queue: all outputs return to reset values asynchronously, and fetch restarts at REBOOT_ADDR.
